// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter sharing one SRAM-like port between instruction fetch and load/store.
// Responses return in order and are steered back to their issuer through a 1-bit owner FIFO.
module sram_bus_arbiter #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wr,
  output logic [1:0]  o_mem_size,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_addr_ok,
  input  logic        i_mem_data_ok,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  logic [MAX_OUT-1:0] r_owner;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [7:0]         r_starve;
  logic               r_err;

  logic        w_can_issue;
  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_mem_req;
  logic        w_accept;
  logic        w_pop;
  logic        w_head;
  logic        w_inst_aok;
  logic        w_spurious;

  assign w_can_issue = (r_count < CW'(MAX_OUT));

  always_comb begin
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    if (w_can_issue) begin
      if ((r_starve == 8'(STARVE_MAX)) && i_inst_req) begin
        w_grant_inst = 1'b1;
      end else if (i_data_req) begin
        w_grant_data = 1'b1;
      end else if (i_inst_req) begin
        w_grant_inst = 1'b1;
      end
    end
  end

  // Every combinational output is forced low while reset is held.
  assign w_mem_req  = ~i_rst & (w_grant_inst | w_grant_data);
  assign w_accept   = w_mem_req & i_mem_addr_ok;
  assign w_pop      = ~i_rst & i_mem_data_ok & (r_count != '0);
  assign w_spurious = i_mem_data_ok & (r_count == '0);
  assign w_head     = r_owner[r_rptr];
  assign w_inst_aok = w_accept & w_grant_inst;

  always_comb begin
    o_mem_wr    = 1'b0;
    o_mem_size  = 2'b00;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    if (!i_rst && w_grant_data) begin
      o_mem_wr    = i_data_wr;
      o_mem_size  = i_data_size;
      o_mem_addr  = i_data_addr;
      o_mem_wdata = i_data_wdata;
    end else if (!i_rst && w_grant_inst) begin
      o_mem_wr    = i_inst_wr;
      o_mem_size  = i_inst_size;
      o_mem_addr  = i_inst_addr;
      o_mem_wdata = i_inst_wdata;
    end
  end

  assign o_mem_req      = w_mem_req;
  assign o_inst_addr_ok = w_inst_aok;
  assign o_data_addr_ok = w_accept & w_grant_data;
  assign o_inst_data_ok = w_pop & ~w_head;
  assign o_data_data_ok = w_pop & w_head;
  assign o_inst_rdata   = (w_pop && !w_head) ? i_mem_rdata : 32'h0;
  assign o_data_rdata   = (w_pop && w_head) ? i_mem_rdata : 32'h0;
  assign o_err          = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner[r_wptr] <= w_grant_data;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (!i_inst_req || w_inst_aok) begin
        r_starve <= 8'd0;
      end else if (r_starve != 8'(STARVE_MAX)) begin
        r_starve <= r_starve + 8'd1;
      end
      if (w_spurious) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_sram_bus_arbiter;
  localparam int MAX_OUT    = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok, err;

  int n_chk = 0;
  int n_err = 0;
  bit q[$];
  int m_starve = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(inst_req), .i_inst_wr(inst_wr), .i_inst_size(inst_size),
    .i_inst_addr(inst_addr), .i_inst_wdata(inst_wdata),
    .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
    .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size),
    .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
    .o_mem_req(mem_req), .o_mem_wr(mem_wr), .o_mem_size(mem_size),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_addr_ok(mem_addr_ok), .i_mem_data_ok(mem_data_ok), .i_mem_rdata(mem_rdata),
    .o_err(err)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Checks every output against the model at mid-cycle, then advances the model.
  task automatic tick();
    int g;
    bit acc, pop, own;
    logic [66:0] ef;
    @(negedge clk);
    if (rst) begin
      check("rst_ctl", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err}, 0);
      check("rst_mem", {mem_wr, mem_size, mem_addr, mem_wdata}, 0);
      check("rst_rdata", {inst_rdata, data_rdata}, 0);
      q.delete();
      m_starve = 0;
      m_err = 0;
    end else begin
      g = 0;
      if (q.size() < MAX_OUT) begin
        if (m_starve == STARVE_MAX && inst_req) g = 1;
        else if (data_req) g = 2;
        else if (inst_req) g = 1;
      end
      acc = (g != 0) && mem_addr_ok;
      pop = mem_data_ok && (q.size() > 0);
      own = pop ? q[0] : 1'b0;
      ef = (g == 1) ? {inst_wr, inst_size, inst_addr, inst_wdata} :
           (g == 2) ? {data_wr, data_size, data_addr, data_wdata} : '0;
      check("mem_req", mem_req, g != 0);
      check("mem_fields", {mem_wr, mem_size, mem_addr, mem_wdata}, ef);
      check("inst_addr_ok", inst_addr_ok, (g == 1) && mem_addr_ok);
      check("data_addr_ok", data_addr_ok, (g == 2) && mem_addr_ok);
      check("inst_data_ok", inst_data_ok, pop && !own);
      check("data_data_ok", data_data_ok, pop && own);
      check("inst_rdata", inst_rdata, (pop && !own) ? mem_rdata : 32'h0);
      check("data_rdata", data_rdata, (pop && own) ? mem_rdata : 32'h0);
      check("err", err, m_err);
      if (mem_data_ok && q.size() == 0) m_err = 1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(g == 2);
      if (inst_req && !((g == 1) && mem_addr_ok))
        m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else
        m_starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  bit own_seq[4] = '{0, 1, 1, 0};

  initial begin
    clear_in();
    tick();
    rst = 0;

    // Priority and routing, slave latency 1
    inst_req = 1; inst_addr = 32'h20; data_req = 1; data_addr = 32'h10; mem_addr_ok = 1;
    #3;
    check("p0_data_aok", data_addr_ok, 1);
    check("p0_inst_aok", inst_addr_ok, 0);
    tick();
    data_req = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA0001;
    #3;
    check("p1_data_dok", data_data_ok, 1);
    check("p1_data_rdata", data_rdata, 32'hAAAA0001);
    check("p1_inst_rdata", inst_rdata, 0);
    check("p1_inst_aok", inst_addr_ok, 1);
    tick();
    inst_req = 0; mem_rdata = 32'h12345678;
    #3;
    check("p2_inst_dok", inst_data_ok, 1);
    check("p2_inst_rdata", inst_rdata, 32'h12345678);
    check("p2_data_rdata", data_rdata, 0);
    check("p2_data_dok", data_data_ok, 0);
    tick();
    clear_in();
    tick();

    // Full: slave stalls responses
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < MAX_OUT; i++) begin
      data_addr = 32'h100 + 4 * i;
      #3;
      check("full_acc", data_addr_ok, 1);
      tick();
    end
    #3;
    check("full_block", mem_req, 0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'h55;
    #3;
    check("full_pop_blk", mem_req, 0);
    check("full_pop_dok", data_data_ok, 1);
    tick();
    mem_data_ok = 0;
    #3;
    check("full_refill", data_addr_ok, 1);
    tick();
    data_req = 0; mem_data_ok = 1;
    for (int i = 0; i < MAX_OUT; i++) tick();
    clear_in();
    tick();

    // Starvation with both masters requesting continuously
    inst_req = 1; data_req = 1; mem_addr_ok = 1; inst_addr = 32'h40; data_addr = 32'h80;
    for (int c = 0; c < 10; c++) begin
      mem_data_ok = (c > 0);
      #3;
      check("starve_inst", inst_addr_ok, c == 8);
      check("starve_data", data_addr_ok, c != 8);
      tick();
    end
    clear_in();
    mem_data_ok = 1;
    tick();
    clear_in();
    tick();

    // Interleaved order, slave latency 3
    for (int c = 0; c < 7; c++) begin
      clear_in();
      if (c < 4) begin
        mem_addr_ok = 1;
        if (own_seq[c]) begin data_req = 1; data_addr = 32'h200 + c; end
        else begin inst_req = 1; inst_addr = 32'h300 + c; end
      end
      if (c >= 3) begin
        mem_data_ok = 1;
        mem_rdata = 32'h1000 + c - 3;
      end
      #3;
      if (c >= 3) begin
        check("ilv_inst_dok", inst_data_ok, !own_seq[c-3]);
        check("ilv_data_dok", data_data_ok, own_seq[c-3]);
        check("ilv_rdata", own_seq[c-3] ? data_rdata : inst_rdata, 32'h1000 + c - 3);
      end
      if (c == 3) check("ilv_push_pop_aok", inst_addr_ok, 1);
      tick();
    end
    clear_in();
    tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      inst_req = 1'($urandom_range(0, 1)); inst_wr = 1'($urandom);
      inst_size = 2'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      data_req = 1'($urandom_range(0, 1)); data_wr = 1'($urandom);
      data_size = 2'($urandom); data_addr = $urandom; data_wdata = $urandom;
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      tick();
    end

    // Asynchronous reset mid-cycle with both requests high
    clear_in();
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    #2;
    check("pre_rst_req", mem_req, q.size() < MAX_OUT);
    rst = 1;
    #1;
    check("async_rst_ctl", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err}, 0);
    check("async_rst_mem", {mem_addr, mem_wdata}, 0);
    tick();
    clear_in();
    rst = 0;

    // Spurious response after reset; err sticky until reset
    mem_data_ok = 1; mem_rdata = 32'hDEAD;
    #3;
    check("spur_dok", {inst_data_ok, data_data_ok}, 0);
    tick();
    mem_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("err_sticky", err, 1);
      tick();
    end
    rst = 1;
    #1;
    check("err_rst", err, 0);
    tick();
    rst = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
